// File: rtl/sass_voice_arbiter.sv
// Single-voice arbiter: live keys preempt sequencer notes, with minimum hold, retrigger gap
// and (with SASS_VOICE_RELEASE_EN defined) a release tail that holds the last pitch.
module sass_voice_arbiter #(
  parameter int unsigned MIN_HOLD       = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned RELEASE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] live_note,
  input  logic [3:0] seq_note,
  input  logic       sequencer_on,
  output logic [3:0] note_out,
  output logic       gate,
  output logic       src_live,
  output logic       preempt
);

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  if (MIN_HOLD < 1) begin : g_bad_hold
    $error("MIN_HOLD must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1");
  end
  if (RELEASE_CYCLES < 1) begin : g_bad_rel
    $error("RELEASE_CYCLES must be >= 1");
  end

`ifdef SASS_VOICE_RELEASE_EN
  localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP, ST_RELEASE} state_t;
  logic [REL_W-1:0] rel_cnt;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;
`endif

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic              live_req;
  logic              seq_req;
  logic              win_req;
  logic [NOTE_W-1:0] win_note;
  logic              hold_done;
  logic              gap_last;
  logic              same_note;

  // Winner selection: live always beats the sequencer
  assign live_req  = |live_note;
  assign seq_req   = sequencer_on & (|seq_note);
  assign win_req   = live_req | seq_req;
  assign win_note  = live_req ? live_note : (seq_req ? seq_note : NOTE_W'(0));
  assign hold_done = (hold_cnt == HOLD_W'(MIN_HOLD - 1));
  assign gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign same_note = win_req && (win_note == note_out) && (live_req == src_live);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      note_out <= '0;
      gate     <= 1'b0;
      src_live <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
`ifdef SASS_VOICE_RELEASE_EN
      rel_cnt  <= '0;
`endif
    end else begin
      preempt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_req) begin
            state    <= ST_PLAY;
            note_out <= win_note;
            src_live <= live_req;
            gate     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_PLAY: begin
          if (same_note) begin
            if (!hold_done) hold_cnt <= hold_cnt + HOLD_W'(1);
          end else if (!src_live && live_req) begin
            // Live preemption ignores the minimum hold
            state   <= ST_GAP;
            gate    <= 1'b0;
            preempt <= 1'b1;
            gap_cnt <= '0;
          end else if (hold_done) begin
            if (win_req) begin
              state   <= ST_GAP;
              gate    <= 1'b0;
              gap_cnt <= '0;
            end else begin
`ifdef SASS_VOICE_RELEASE_EN
              state   <= ST_RELEASE;
              gate    <= 1'b0;
              rel_cnt <= '0;
`else
              state    <= ST_IDLE;
              gate     <= 1'b0;
              note_out <= '0;
              src_live <= 1'b0;
`endif
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            if (win_req) begin
              state    <= ST_PLAY;
              note_out <= win_note;
              src_live <= live_req;
              gate     <= 1'b1;
              hold_cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              note_out <= '0;
              src_live <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`ifdef SASS_VOICE_RELEASE_EN
        ST_RELEASE: begin
          // A new request during the tail retriggers without a gap
          if (win_req) begin
            state    <= ST_PLAY;
            note_out <= win_note;
            src_live <= live_req;
            gate     <= 1'b1;
            hold_cnt <= '0;
          end else if (rel_cnt == REL_W'(RELEASE_CYCLES - 1)) begin
            state    <= ST_IDLE;
            note_out <= '0;
            src_live <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + REL_W'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sass_voice_arbiter.sv
// Directed bench for sass_voice_arbiter (MIN_HOLD=4, GAP_CYCLES=2, RELEASE_CYCLES=3);
// expectations follow the build's SASS_VOICE_RELEASE_EN setting.
module tb_sass_voice_arbiter;

  logic       clk;
  logic       n_rst;
  logic [3:0] live_note;
  logic [3:0] seq_note;
  logic       sequencer_on;
  logic [3:0] note_out;
  logic       gate;
  logic       src_live;
  logic       preempt;

  int n_checks;
  int n_fail;

  sass_voice_arbiter #(
    .MIN_HOLD(4),
    .GAP_CYCLES(2),
    .RELEASE_CYCLES(3)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .live_note(live_note),
    .seq_note(seq_note),
    .sequencer_on(sequencer_on),
    .note_out(note_out),
    .gate(gate),
    .src_live(src_live),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] n, input logic g);
    check({tag, "_note"}, 8'(note_out), 8'(n));
    check({tag, "_gate"}, 8'(gate), 8'(g));
  endtask

  // Called right after the last gate-high cycle with no request pending
  task automatic end_of_note(input string tag, input logic [3:0] n);
`ifdef SASS_VOICE_RELEASE_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out({tag, "_rel"}, n, 1'b0);
    end
`endif
    tick();
    expect_out({tag, "_idle"}, 4'd0, 1'b0);
    check({tag, "_idle_src"}, 8'(src_live), 8'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    n_rst = 1'b0;
    live_note = '0;
    seq_note = '0;
    sequencer_on = 1'b0;
    tick();
    tick();
    expect_out("rst", 4'd0, 1'b0);
    check("rst_src", 8'(src_live), 8'd0);
    check("rst_pre", 8'(preempt), 8'd0);
    n_rst = 1'b1;
    tick();
    tick();
    expect_out("post_rst", 4'd0, 1'b0);

    // Live preempts a sequencer note after one cycle
    seq_note = 4'd7;
    sequencer_on = 1'b1;
    tick();
    expect_out("seq7", 4'd7, 1'b1);
    check("seq7_src", 8'(src_live), 8'd0);
    check("seq7_pre", 8'(preempt), 8'd0);
    live_note = 4'd2;
    tick();
    expect_out("pre_gap0", 4'd7, 1'b0);
    check("pre_pulse", 8'(preempt), 8'd1);
    tick();
    expect_out("pre_gap1", 4'd7, 1'b0);
    check("pre_no_repeat", 8'(preempt), 8'd0);
    tick();
    expect_out("live2", 4'd2, 1'b1);
    check("live2_src", 8'(src_live), 8'd1);
    check("live2_pre", 8'(preempt), 8'd0);
    live_note = '0;
    seq_note = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("live2_hold", 4'd2, 1'b1);
    end
    end_of_note("live2_end", 4'd2);

    // Short live tap is stretched to the minimum hold
    live_note = 4'd3;
    tick();
    expect_out("tap", 4'd3, 1'b1);
    check("tap_src", 8'(src_live), 8'd1);
    live_note = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("tap_hold", 4'd3, 1'b1);
    end
    end_of_note("tap_end", 4'd3);

    // Sequencer step change late in a note, then early in a note
    seq_note = 4'd4;
    tick();
    expect_out("s4", 4'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("s4_hold", 4'd4, 1'b1);
    end
    seq_note = 4'd9;
    tick();
    expect_out("s9_gap0", 4'd4, 1'b0);
    check("s9_no_pre", 8'(preempt), 8'd0);
    tick();
    expect_out("s9_gap1", 4'd4, 1'b0);
    tick();
    expect_out("s9", 4'd9, 1'b1);
    check("s9_src", 8'(src_live), 8'd0);
    seq_note = 4'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("s9_defer", 4'd9, 1'b1);
    end
    tick();
    expect_out("s4b_gap0", 4'd9, 1'b0);
    tick();
    expect_out("s4b_gap1", 4'd9, 1'b0);
    tick();
    expect_out("s4b", 4'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("s4b_hold", 4'd4, 1'b1);
    end
    // sequencer_on drops after hold_done
    sequencer_on = 1'b0;
    end_of_note("seq_off", 4'd4);
    seq_note = '0;

`ifdef SASS_VOICE_RELEASE_EN
    // Retrigger from the release tail skips the gap
    live_note = 4'd6;
    tick();
    expect_out("l6", 4'd6, 1'b1);
    live_note = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("l6_hold", 4'd6, 1'b1);
    end
    tick();
    expect_out("l6_rel0", 4'd6, 1'b0);
    tick();
    expect_out("l6_rel1", 4'd6, 1'b0);
    live_note = 4'd8;
    tick();
    expect_out("l8_retrig", 4'd8, 1'b1);
    check("l8_src", 8'(src_live), 8'd1);
    live_note = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("l8_hold", 4'd8, 1'b1);
    end
    end_of_note("l8_end", 4'd8);
`endif

    // Asynchronous reset in the middle of a note
    live_note = 4'd5;
    tick();
    expect_out("l5", 4'd5, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    expect_out("async_rst", 4'd0, 1'b0);
    check("async_rst_src", 8'(src_live), 8'd0);
    live_note = '0;
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    expect_out("after_rst", 4'd0, 1'b0);
    check("after_rst_pre", 8'(preempt), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
